// File: rtl/tl_ul_source_arbiter.sv
// Two-master TL-UL arbiter: round-robin on channel A, upstream source remapped onto a
// small pool of downstream IDs, channel D routed back to the owner with its source restored.
module tl_ul_source_arbiter #(
  parameter int unsigned IDS = 4,
  localparam int unsigned DSRC_W = $clog2(IDS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_a_valid,
  input  logic [2:0]        m0_a_opcode,
  input  logic [2:0]        m0_a_param,
  input  logic [2:0]        m0_a_size,
  input  logic [4:0]        m0_a_source,
  input  logic [31:0]       m0_a_address,
  input  logic [3:0]        m0_a_mask,
  input  logic [31:0]       m0_a_data,
  output logic              m0_a_ready,
  input  logic              m1_a_valid,
  input  logic [2:0]        m1_a_opcode,
  input  logic [2:0]        m1_a_param,
  input  logic [2:0]        m1_a_size,
  input  logic [4:0]        m1_a_source,
  input  logic [31:0]       m1_a_address,
  input  logic [3:0]        m1_a_mask,
  input  logic [31:0]       m1_a_data,
  output logic              m1_a_ready,
  output logic              m0_d_valid,
  output logic [2:0]        m0_d_opcode,
  output logic [1:0]        m0_d_param,
  output logic [2:0]        m0_d_size,
  output logic [4:0]        m0_d_source,
  output logic              m0_d_denied,
  output logic [31:0]       m0_d_data,
  output logic              m0_d_corrupt,
  input  logic              m0_d_ready,
  output logic              m1_d_valid,
  output logic [2:0]        m1_d_opcode,
  output logic [1:0]        m1_d_param,
  output logic [2:0]        m1_d_size,
  output logic [4:0]        m1_d_source,
  output logic              m1_d_denied,
  output logic [31:0]       m1_d_data,
  output logic              m1_d_corrupt,
  input  logic              m1_d_ready,
  output logic              dn_a_valid,
  output logic [2:0]        dn_a_opcode,
  output logic [2:0]        dn_a_param,
  output logic [2:0]        dn_a_size,
  output logic [DSRC_W-1:0] dn_a_source,
  output logic [31:0]       dn_a_address,
  output logic [3:0]        dn_a_mask,
  output logic [31:0]       dn_a_data,
  input  logic              dn_a_ready,
  input  logic              dn_d_valid,
  input  logic [2:0]        dn_d_opcode,
  input  logic [1:0]        dn_d_param,
  input  logic [2:0]        dn_d_size,
  input  logic [DSRC_W-1:0] dn_d_source,
  input  logic              dn_d_denied,
  input  logic [31:0]       dn_d_data,
  input  logic              dn_d_corrupt,
  output logic              dn_d_ready,
  output logic [IDS-1:0]    busy,
  output logic              err_orphan
);

  logic              rr;
  logic              lock;
  logic              lock_owner;
  logic [DSRC_W-1:0] lock_src;
  logic              tbl_owner [IDS];
  logic [4:0]        tbl_src   [IDS];

  logic              grant;
  logic              have_free;
  logic [DSRC_W-1:0] free_id;
  logic              a_fire;
  logic              d_hit;
  logic              d_owner;
  logic [4:0]        d_src;
  logic              d_fire;
  logic [IDS-1:0]    busy_nxt;

  // Lowest-index free downstream ID
  always_comb begin
    free_id = '0;
    for (int i = int'(IDS) - 1; i >= 0; i--) begin
      if (!busy[i]) free_id = DSRC_W'(i);
    end
  end

  assign have_free = ~&busy;

  always_comb begin
    if (lock)                          grant = lock_owner;
    else if (m0_a_valid ^ m1_a_valid)  grant = m1_a_valid;
    else                               grant = rr;
  end

  assign dn_a_valid   = (grant ? m1_a_valid : m0_a_valid) & have_free;
  assign dn_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
  assign dn_a_param   = grant ? m1_a_param   : m0_a_param;
  assign dn_a_size    = grant ? m1_a_size    : m0_a_size;
  assign dn_a_address = grant ? m1_a_address : m0_a_address;
  assign dn_a_mask    = grant ? m1_a_mask    : m0_a_mask;
  assign dn_a_data    = grant ? m1_a_data    : m0_a_data;
  // A stalled request keeps the ID it was first offered with, even if a lower one frees up
  assign dn_a_source  = lock ? lock_src : free_id;

  assign a_fire     = dn_a_valid & dn_a_ready;
  assign m0_a_ready = ~grant & dn_a_ready & have_free;
  assign m1_a_ready =  grant & dn_a_ready & have_free;

  assign d_hit   = busy[dn_d_source];
  assign d_owner = tbl_owner[dn_d_source];
  assign d_src   = tbl_src[dn_d_source];

  assign m0_d_valid   = dn_d_valid & d_hit & ~d_owner;
  assign m1_d_valid   = dn_d_valid & d_hit &  d_owner;
  assign m0_d_source  = d_src;
  assign m1_d_source  = d_src;
  assign m0_d_opcode  = dn_d_opcode;
  assign m1_d_opcode  = dn_d_opcode;
  assign m0_d_param   = dn_d_param;
  assign m1_d_param   = dn_d_param;
  assign m0_d_size    = dn_d_size;
  assign m1_d_size    = dn_d_size;
  assign m0_d_denied  = dn_d_denied;
  assign m1_d_denied  = dn_d_denied;
  assign m0_d_data    = dn_d_data;
  assign m1_d_data    = dn_d_data;
  assign m0_d_corrupt = dn_d_corrupt;
  assign m1_d_corrupt = dn_d_corrupt;

  // Orphan responses are swallowed so a stray D can never wedge the downstream port
  assign dn_d_ready = d_hit ? (d_owner ? m1_d_ready : m0_d_ready) : 1'b1;
  assign d_fire     = dn_d_valid & dn_d_ready & d_hit;

  always_comb begin
    busy_nxt = busy;
    if (d_fire) busy_nxt[dn_d_source] = 1'b0;
    if (a_fire) busy_nxt[dn_a_source] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy       <= '0;
      rr         <= 1'b0;
      lock       <= 1'b0;
      lock_owner <= 1'b0;
      lock_src   <= '0;
      err_orphan <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (a_fire) begin
        rr   <= ~grant;
        lock <= 1'b0;
      end else if (dn_a_valid) begin
        lock       <= 1'b1;
        lock_owner <= grant;
        lock_src   <= dn_a_source;
      end
      if (dn_d_valid & ~d_hit) err_orphan <= 1'b1;
    end
  end

  // Source table needs no reset: entries are only read while their busy bit is set
  always_ff @(posedge clock) begin
    if (a_fire) begin
      tbl_owner[dn_a_source] <= grant;
      tbl_src[dn_a_source]   <= grant ? m1_a_source : m0_a_source;
    end
  end

endmodule

// File: tb/tb_tl_ul_source_arbiter.sv
// Directed and randomized bench for tl_ul_source_arbiter, checked against a
// transaction-level model (outstanding map, pending request, round-robin preference).
module tb_tl_ul_source_arbiter;

  localparam int unsigned IDS    = 4;
  localparam int unsigned DSRC_W = 2;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        m0_a_valid, m1_a_valid, m0_a_ready, m1_a_ready;
  logic [2:0]  m0_a_opcode, m1_a_opcode, m0_a_param, m1_a_param, m0_a_size, m1_a_size;
  logic [4:0]  m0_a_source, m1_a_source;
  logic [31:0] m0_a_address, m1_a_address, m0_a_data, m1_a_data;
  logic [3:0]  m0_a_mask, m1_a_mask;
  logic        m0_d_valid, m1_d_valid, m0_d_ready, m1_d_ready;
  logic [2:0]  m0_d_opcode, m1_d_opcode, m0_d_size, m1_d_size;
  logic [1:0]  m0_d_param, m1_d_param;
  logic [4:0]  m0_d_source, m1_d_source;
  logic        m0_d_denied, m1_d_denied, m0_d_corrupt, m1_d_corrupt;
  logic [31:0] m0_d_data, m1_d_data;
  logic        dn_a_valid, dn_a_ready;
  logic [2:0]  dn_a_opcode, dn_a_param, dn_a_size;
  logic [DSRC_W-1:0] dn_a_source;
  logic [31:0] dn_a_address, dn_a_data;
  logic [3:0]  dn_a_mask;
  logic        dn_d_valid, dn_d_ready, dn_d_denied, dn_d_corrupt;
  logic [2:0]  dn_d_opcode, dn_d_size;
  logic [1:0]  dn_d_param;
  logic [DSRC_W-1:0] dn_d_source;
  logic [31:0] dn_d_data;
  logic [IDS-1:0] busy;
  logic        err_orphan;

  tl_ul_source_arbiter #(.IDS(IDS)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_a_valid(m0_a_valid), .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param),
    .m0_a_size(m0_a_size), .m0_a_source(m0_a_source), .m0_a_address(m0_a_address),
    .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data), .m0_a_ready(m0_a_ready),
    .m1_a_valid(m1_a_valid), .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param),
    .m1_a_size(m1_a_size), .m1_a_source(m1_a_source), .m1_a_address(m1_a_address),
    .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data), .m1_a_ready(m1_a_ready),
    .m0_d_valid(m0_d_valid), .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param),
    .m0_d_size(m0_d_size), .m0_d_source(m0_d_source), .m0_d_denied(m0_d_denied),
    .m0_d_data(m0_d_data), .m0_d_corrupt(m0_d_corrupt), .m0_d_ready(m0_d_ready),
    .m1_d_valid(m1_d_valid), .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param),
    .m1_d_size(m1_d_size), .m1_d_source(m1_d_source), .m1_d_denied(m1_d_denied),
    .m1_d_data(m1_d_data), .m1_d_corrupt(m1_d_corrupt), .m1_d_ready(m1_d_ready),
    .dn_a_valid(dn_a_valid), .dn_a_opcode(dn_a_opcode), .dn_a_param(dn_a_param),
    .dn_a_size(dn_a_size), .dn_a_source(dn_a_source), .dn_a_address(dn_a_address),
    .dn_a_mask(dn_a_mask), .dn_a_data(dn_a_data), .dn_a_ready(dn_a_ready),
    .dn_d_valid(dn_d_valid), .dn_d_opcode(dn_d_opcode), .dn_d_param(dn_d_param),
    .dn_d_size(dn_d_size), .dn_d_source(dn_d_source), .dn_d_denied(dn_d_denied),
    .dn_d_data(dn_d_data), .dn_d_corrupt(dn_d_corrupt), .dn_d_ready(dn_d_ready),
    .busy(busy), .err_orphan(err_orphan)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: outstanding[id] = {owner, upstream source}
  logic [5:0] outstanding [int];
  bit  pref;
  bit  pend_v, pend_m;
  int  pend_id;
  bit  orphan_seen;
  bit  last_afire, last_g, last_dfire;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < int'(IDS); i++) if (!outstanding.exists(i)) return i;
    return -1;
  endfunction

  task automatic settle();
    #1;
  endtask

  // Check every output against the model, take one clock edge, advance the model.
  task automatic cycle();
    bit v0, v1, g, hf, ev, hit, own, rdy_a, dv, routed_rdy, edr;
    int eid, did;
    logic [4:0] s0, s1;
    logic [IDS-1:0] eb;
    v0 = m0_a_valid; v1 = m1_a_valid; s0 = m0_a_source; s1 = m1_a_source;
    if (pend_v)       g = pend_m;
    else if (v0 != v1) g = v1;
    else              g = pref;
    hf  = outstanding.num() < int'(IDS);
    eid = pend_v ? pend_id : lowest_free();
    ev  = (g ? v1 : v0) && hf;
    chk("dn_a_valid", 64'(dn_a_valid), 64'(ev));
    if (ev) begin
      chk("dn_a_source", 64'(dn_a_source), 64'(eid));
      chk("dn_a_address", 64'(dn_a_address), 64'(g ? m1_a_address : m0_a_address));
      chk("dn_a_data", 64'(dn_a_data), 64'(g ? m1_a_data : m0_a_data));
    end
    chk("m0_a_ready", 64'(m0_a_ready), 64'(!g && dn_a_ready && hf));
    chk("m1_a_ready", 64'(m1_a_ready), 64'(g && dn_a_ready && hf));
    did = int'(dn_d_source);
    dv  = dn_d_valid;
    hit = outstanding.exists(did);
    own = hit ? outstanding[did][5] : 1'b0;
    routed_rdy = own ? m1_d_ready : m0_d_ready;
    edr = hit ? routed_rdy : 1'b1;
    chk("dn_d_ready", 64'(dn_d_ready), 64'(edr));
    chk("m0_d_valid", 64'(m0_d_valid), 64'(dv && hit && !own));
    chk("m1_d_valid", 64'(m1_d_valid), 64'(dv && hit && own));
    if (dv && hit) begin
      chk("d_source", 64'(own ? m1_d_source : m0_d_source), 64'(outstanding[did][4:0]));
      chk("d_data", 64'(own ? m1_d_data : m0_d_data), 64'(dn_d_data));
    end
    for (int i = 0; i < int'(IDS); i++) eb[i] = outstanding.exists(i);
    chk("busy", 64'(busy), 64'(eb));
    chk("err_orphan", 64'(err_orphan), 64'(orphan_seen));
    rdy_a = dn_a_ready;
    @(posedge clock);
    last_afire = ev && rdy_a;
    last_g     = g;
    last_dfire = dv && (!hit || routed_rdy);
    if (dv && hit && routed_rdy) outstanding.delete(did);
    if (dv && !hit) orphan_seen = 1'b1;
    if (last_afire) begin
      outstanding[eid] = {g, g ? s1 : s0};
      pref   = !g;
      pend_v = 1'b0;
    end else if (ev) begin
      pend_v = 1'b1; pend_m = g; pend_id = eid;
    end
    #1;
  endtask

  task automatic set_req(input int m, input bit v, input logic [4:0] s, input logic [31:0] a,
                         input logic [2:0] op);
    if (m == 0) begin
      m0_a_valid = v; m0_a_source = s; m0_a_address = a; m0_a_opcode = op;
      m0_a_data = a ^ 32'h5A5A_0000; m0_a_mask = 4'hF; m0_a_size = 3'd2; m0_a_param = 3'd0;
    end else begin
      m1_a_valid = v; m1_a_source = s; m1_a_address = a; m1_a_opcode = op;
      m1_a_data = a ^ 32'hA5A5_0000; m1_a_mask = 4'hF; m1_a_size = 3'd2; m1_a_param = 3'd0;
    end
  endtask

  task automatic set_d(input bit v, input int id, input logic [31:0] data);
    dn_d_valid = v; dn_d_source = DSRC_W'(id); dn_d_data = data; dn_d_opcode = 3'd1;
    dn_d_param = 2'd0; dn_d_size = 3'd2; dn_d_denied = 1'b0; dn_d_corrupt = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_req(0, 0, 5'd0, 32'd0, 3'd4);
    set_req(1, 0, 5'd0, 32'd0, 3'd4);
    set_d(0, 0, 32'd0);
    dn_a_ready = 1'b0; m0_d_ready = 1'b0; m1_d_ready = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    outstanding.delete();
    pref = 1'b0; pend_v = 1'b0; pend_m = 1'b0; pend_id = 0; orphan_seen = 1'b0;
  endtask

  task automatic rand_master(input int m);
    bit v, consumed;
    v = (m == 0) ? m0_a_valid : m1_a_valid;
    consumed = last_afire && (int'(last_g) == m);
    if (!v || consumed) begin
      if ($urandom_range(0, 9) < 6) begin
        logic [2:0] op;
        case ($urandom_range(0, 2))
          0: op = 3'd0;
          1: op = 3'd1;
          default: op = 3'd4;
        endcase
        set_req(m, 1'b1, 5'($urandom_range(0, 31)), $urandom, op);
      end else begin
        set_req(m, 1'b0, 5'd0, 32'd0, 3'd4);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Reset state
    settle();
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err_orphan), 64'h0);
    chk("rst_dn_a_valid", 64'(dn_a_valid), 64'h0);
    chk("rst_m0_d_valid", 64'(m0_d_valid), 64'h0);
    cycle();

    // Single Get from m0
    set_req(0, 1, 5'h13, 32'h0000_1000, 3'd4);
    dn_a_ready = 1'b1;
    settle();
    chk("single_valid", 64'(dn_a_valid), 64'h1);
    chk("single_src", 64'(dn_a_source), 64'h0);
    chk("single_addr", 64'(dn_a_address), 64'h1000);
    chk("single_opcode", 64'(dn_a_opcode), 64'h4);
    cycle();
    chk("single_busy", 64'(busy), 64'b0001);
    set_req(0, 0, 5'h0, 32'h0, 3'd4);
    set_d(1, 0, 32'hCAFE_F00D);
    m0_d_ready = 1'b1;
    settle();
    chk("single_d_valid", 64'(m0_d_valid), 64'h1);
    chk("single_d_source", 64'(m0_d_source), 64'h13);
    chk("single_d_data", 64'(m0_d_data), 64'hCAFE_F00D);
    chk("single_d_m1", 64'(m1_d_valid), 64'h0);
    cycle();
    chk("single_busy_free", 64'(busy), 64'b0000);
    set_d(0, 0, 32'd0);

    // Contention: alternating grants, IDs 0..3, then stall until a D frees ID 2
    do_reset();
    set_req(0, 1, 5'h02, 32'h0000_0100, 3'd4);
    set_req(1, 1, 5'h07, 32'h0000_0200, 3'd4);
    dn_a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("cont_id", 64'(dn_a_source), 64'(k));
      chk("cont_m0_grant", 64'(m0_a_ready), 64'((k % 2) == 0));
      cycle();
    end
    settle();
    chk("cont_stall", 64'(dn_a_valid), 64'h0);
    chk("cont_busy", 64'(busy), 64'b1111);
    cycle();
    set_d(1, 2, 32'h1234_5678);
    m0_d_ready = 1'b1;
    settle();
    chk("same_cycle_no_a", 64'(dn_a_valid), 64'h0);
    chk("same_cycle_d", 64'(m0_d_valid), 64'h1);
    cycle();
    set_d(0, 0, 32'd0);
    settle();
    chk("realloc_valid", 64'(dn_a_valid), 64'h1);
    chk("realloc_id", 64'(dn_a_source), 64'h2);
    chk("realloc_m0", 64'(m0_a_ready), 64'h1);
    cycle();

    // Backpressure lock on m1 while m0 is also requesting
    do_reset();
    set_req(1, 1, 5'h09, 32'h0000_2000, 3'd4);
    settle();
    cycle();
    set_req(0, 1, 5'h04, 32'h0000_1000, 3'd4);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("lock_addr", 64'(dn_a_address), 64'h2000);
      chk("lock_src", 64'(dn_a_source), 64'h0);
      chk("lock_m0_rdy", 64'(m0_a_ready), 64'h0);
      cycle();
    end
    dn_a_ready = 1'b1;
    settle();
    chk("lock_fire_m1", 64'(m1_a_ready), 64'h1);
    cycle();
    set_req(1, 0, 5'h0, 32'h0, 3'd4);
    settle();
    chk("lock_next_m0", 64'(m0_a_ready), 64'h1);
    chk("lock_next_id", 64'(dn_a_source), 64'h1);
    cycle();

    // Out-of-order D with upstream backpressure on m1
    do_reset();
    dn_a_ready = 1'b1;
    set_req(0, 1, 5'h02, 32'h0000_0010, 3'd4);
    settle();
    cycle();
    set_req(0, 0, 5'h0, 32'h0, 3'd4);
    set_req(1, 1, 5'h07, 32'h0000_0020, 3'd4);
    settle();
    cycle();
    set_req(1, 0, 5'h0, 32'h0, 3'd4);
    set_d(1, 1, 32'h0BAD_BEEF);
    m0_d_ready = 1'b1; m1_d_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("ooo_dn_d_ready", 64'(dn_d_ready), 64'h0);
      chk("ooo_m1_valid", 64'(m1_d_valid), 64'h1);
      chk("ooo_m0_valid", 64'(m0_d_valid), 64'h0);
      cycle();
    end
    m1_d_ready = 1'b1;
    settle();
    chk("ooo_m1_src", 64'(m1_d_source), 64'h7);
    chk("ooo_dn_d_ready1", 64'(dn_d_ready), 64'h1);
    cycle();
    chk("ooo_busy", 64'(busy), 64'b0001);
    set_d(0, 0, 32'd0);

    // Orphan response, then reset restores m0 preference
    do_reset();
    dn_a_ready = 1'b1; m0_d_ready = 1'b1;
    set_req(0, 1, 5'h01, 32'h0000_0030, 3'd4);
    settle();
    cycle();
    set_req(0, 0, 5'h0, 32'h0, 3'd4);
    set_d(1, 0, 32'h1);
    settle();
    cycle();
    set_d(1, 3, 32'hDEAD_0003);
    settle();
    chk("orph_ready", 64'(dn_d_ready), 64'h1);
    chk("orph_m0", 64'(m0_d_valid), 64'h0);
    chk("orph_m1", 64'(m1_d_valid), 64'h0);
    cycle();
    set_d(0, 0, 32'd0);
    chk("orph_err", 64'(err_orphan), 64'h1);
    do_reset();
    chk("orph_rst_err", 64'(err_orphan), 64'h0);
    chk("orph_rst_busy", 64'(busy), 64'h0);
    dn_a_ready = 1'b1;
    set_req(0, 1, 5'h05, 32'h0000_0040, 3'd4);
    set_req(1, 1, 5'h06, 32'h0000_0050, 3'd4);
    settle();
    chk("rst_pref_m0", 64'(m0_a_ready), 64'h1);
    chk("rst_pref_m1", 64'(m1_a_ready), 64'h0);
    cycle();

    // Randomized traffic; both sides hold a request until it is accepted
    do_reset();
    last_afire = 1'b0; last_dfire = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rand_master(0);
      rand_master(1);
      dn_a_ready = ($urandom_range(0, 3) != 0);
      m0_d_ready = ($urandom_range(0, 3) != 0);
      m1_d_ready = ($urandom_range(0, 3) != 0);
      if (!dn_d_valid || last_dfire) begin
        int r;
        r = int'($urandom_range(0, IDS - 1));
        if (outstanding.exists(r)) set_d($urandom_range(0, 9) < 7, r, $urandom);
        else                       set_d($urandom_range(0, 39) == 0, r, $urandom);
      end
      settle();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
